// File: rtl/sound_ac97_tx.sv
// sound_ac97_tx: AC97 controller transmit side, driving the SDATA_OUT/SYNC lines.
// A free-running 8-bit bit counter defines a 256-bit frame. At count 0 the
// frame is assembled from the PCM inputs and the one-entry command buffer, then
// shifted out MSB first with a single cycle of latency.
//
// Ports:
//   I_CLK        AC97 BIT_CLK; the only clock, rising edge
//   I_RESET      synchronous active-high reset
//   I_PCM_LEFT   20-bit left sample (two's complement)
//   I_PCM_RIGHT  20-bit right sample (two's complement)
//   I_PCM_VALID  PCM inputs valid for the next frame
//   I_CMD_VALID  codec register command request
//   I_CMD_RD     1 = register read, 0 = register write
//   I_CMD_ADDR   7-bit codec register index
//   I_CMD_DATA   16-bit register write data
//   O_CMD_READY  command buffer empty (low during reset)
//   O_SYNC       AC97 SYNC, high for the 16 tag bits
//   O_SDATA_OUT  AC97 serial data, MSB first
//   O_STROBE     one-cycle pulse alongside the first tag bit
module sound_ac97_tx (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [19:0] I_PCM_LEFT,
  input  logic [19:0] I_PCM_RIGHT,
  input  logic        I_PCM_VALID,
  input  logic        I_CMD_VALID,
  input  logic        I_CMD_RD,
  input  logic [6:0]  I_CMD_ADDR,
  input  logic [15:0] I_CMD_DATA,
  output logic        O_CMD_READY,
  output logic        O_SYNC,
  output logic        O_SDATA_OUT,
  output logic        O_STROBE
);

  logic [7:0]  bit_cnt;
  logic        load;
  logic        accept;

  logic        cmd_full;
  logic        cmd_rd;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;

  // Only frame bits 255..160 ever carry data; bits 159..0 are always zero, so
  // the shifter holds just the upper 96 bits and back-fills zeros.
  logic [95:0] frame_next;
  logic [95:0] shreg;

  assign load   = (bit_cnt == '0);
  assign accept = I_CMD_VALID && O_CMD_READY;

  always_comb begin
    O_CMD_READY = !cmd_full && !I_RESET;
  end

  // Frame image built from state sampled before the load edge.
  always_comb begin
    frame_next     = '0;
    // slot 0: tag
    frame_next[95] = 1'b1;
    frame_next[94] = cmd_full;
    frame_next[93] = cmd_full && !cmd_rd;
    frame_next[92] = I_PCM_VALID;
    frame_next[91] = I_PCM_VALID;
    // slot 1: command address
    if (cmd_full) begin
      frame_next[79:60] = {cmd_rd, cmd_addr, 12'h000};
    end
    // slot 2: command data, writes only
    if (cmd_full && !cmd_rd) begin
      frame_next[59:40] = {cmd_data, 4'h0};
    end
    // slots 3 and 4: PCM left/right
    if (I_PCM_VALID) begin
      frame_next[39:20] = I_PCM_LEFT;
      frame_next[19:0]  = I_PCM_RIGHT;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      O_SDATA_OUT <= 1'b0;
      O_SYNC      <= 1'b0;
      O_STROBE    <= 1'b0;
    end else begin
      bit_cnt  <= bit_cnt + 8'd1;
      O_SYNC   <= (bit_cnt < 8'd16);
      O_STROBE <= load;
      // The first bit of a new frame comes straight from the assembled image,
      // the remainder is parked in the shifter for the following cycles.
      if (load) begin
        O_SDATA_OUT <= frame_next[95];
        shreg       <= {frame_next[94:0], 1'b0};
      end else begin
        O_SDATA_OUT <= shreg[95];
        shreg       <= {shreg[94:0], 1'b0};
      end
    end
  end

  // One-entry command buffer. A command accepted on the load edge misses the
  // frame being assembled (tag uses cmd_full from before the edge) and so goes
  // out in the next one. Acceptance requires an empty buffer, so a load that
  // clears the buffer never coincides with a new acceptance.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      cmd_full <= 1'b0;
      cmd_rd   <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
    end else if (load && cmd_full) begin
      cmd_full <= 1'b0;
    end else if (accept) begin
      cmd_full <= 1'b1;
      cmd_rd   <= I_CMD_RD;
      cmd_addr <= I_CMD_ADDR;
      cmd_data <= I_CMD_DATA;
    end
  end

endmodule

// File: tb/tb_sound_ac97_tx.sv
// Self-checking bench for sound_ac97_tx: a negedge monitor rebuilds every
// serial frame; directed table vectors and hand sequences check its contents.
module tb_sound_ac97_tx;

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic [19:0] I_PCM_LEFT;
  logic [19:0] I_PCM_RIGHT;
  logic        I_PCM_VALID;
  logic        I_CMD_VALID;
  logic        I_CMD_RD;
  logic [6:0]  I_CMD_ADDR;
  logic [15:0] I_CMD_DATA;
  logic        O_CMD_READY;
  logic        O_SYNC;
  logic        O_SDATA_OUT;
  logic        O_STROBE;

  sound_ac97_tx dut (
    .I_CLK       (I_CLK),
    .I_RESET     (I_RESET),
    .I_PCM_LEFT  (I_PCM_LEFT),
    .I_PCM_RIGHT (I_PCM_RIGHT),
    .I_PCM_VALID (I_PCM_VALID),
    .I_CMD_VALID (I_CMD_VALID),
    .I_CMD_RD    (I_CMD_RD),
    .I_CMD_ADDR  (I_CMD_ADDR),
    .I_CMD_DATA  (I_CMD_DATA),
    .O_CMD_READY (O_CMD_READY),
    .O_SYNC      (O_SYNC),
    .O_SDATA_OUT (O_SDATA_OUT),
    .O_STROBE    (O_STROBE)
  );

  always #5 I_CLK = ~I_CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- frame monitor ----------------
  typedef struct {
    logic [255:0] f;
    bit           ok;       // SYNC/STROBE shape and 256-cycle period correct
    bit           aborted;  // cut short by reset
  } frm_t;

  frm_t         frames[$];
  int           nstart = 0;
  int           idx = 0;
  int           gap = 0;
  bit           active = 0;
  bit           fresh = 1;
  bit           cur_ok;
  logic [255:0] cur;

  always @(negedge I_CLK) begin
    if (I_RESET) begin
      if (active) frames.push_back('{cur, 1'b0, 1'b1});
      active = 0;
      fresh  = 1;
      gap    = 0;
    end else begin
      if (!active) begin
        if (O_STROBE === 1'b1) begin
          active = 1;
          idx    = 0;
          cur    = '0;
          cur_ok = fresh || (gap == 0);
          fresh  = 0;
          nstart++;
        end else begin
          gap++;
        end
      end
      if (active) begin
        cur[255-idx] = O_SDATA_OUT;
        if (O_SYNC !== (idx < 16)) cur_ok = 0;
        if (O_STROBE !== (idx == 0)) cur_ok = 0;
        idx++;
        if (idx == 256) begin
          frames.push_back('{cur, cur_ok, 1'b0});
          active = 0;
          gap    = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Step to just after the next falling edge (monitor has already sampled).
  task automatic step();
    @(negedge I_CLK);
    #1;
  endtask

  task automatic wait_strobe(input string nm, output logic prev_ready);
    int t = 0;
    prev_ready = O_CMD_READY;
    while (O_STROBE !== 1'b1 && t < 600) begin
      prev_ready = O_CMD_READY;
      step();
      t++;
    end
    if (O_STROBE !== 1'b1) check({nm, "_strobe_timeout"}, 80'd0, 80'd1);
  endtask

  task automatic check_frame(input string nm, input int n, input logic [15:0] tag,
                             input logic [19:0] s1, input logic [19:0] s2,
                             input logic [19:0] s3, input logic [19:0] s4);
    int t = 0;
    logic [255:0] f;
    while (frames.size() <= n && t < 1200) begin
      step();
      t++;
    end
    if (frames.size() <= n) begin
      check({nm, "_frame_timeout"}, 80'd0, 80'd1);
      return;
    end
    f = frames[n].f;
    check({nm, "_tag"},   {64'd0, f[255:240]}, {64'd0, tag});
    check({nm, "_slots"}, f[239:160], {s1, s2, s3, s4});
    check({nm, "_rest"},  {64'd0, f[159:144]} | (f[159:0] != '0 ? 80'd1 : 80'd0), 80'd0);
    check({nm, "_shape"}, {78'd0, frames[n].ok, frames[n].aborted}, 80'd2);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        pv;
    logic [19:0] l;
    logic [19:0] r;
    logic        cmd;
    logic        rd;
    logic [6:0]  a;
    logic [15:0] d;
    logic [15:0] tag;
    logic [19:0] s1;
    logic [19:0] s2;
    logic [19:0] s3;
    logic [19:0] s4;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_ready;
    int   n;

    //            pv   left      right     cmd  rd   addr   data      tag       slot1     slot2     slot3     slot4
    vecs[0] = '{1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0, 7'h00, 16'h0000, 16'h8000, 20'h00000, 20'h00000, 20'h00000, 20'h00000};
    vecs[1] = '{1'b1, 20'h7FFFF, 20'h80001, 1'b0, 1'b0, 7'h00, 16'h0000, 16'h9800, 20'h00000, 20'h00000, 20'h7FFFF, 20'h80001};
    vecs[2] = '{1'b0, 20'h12345, 20'h54321, 1'b1, 1'b0, 7'h02, 16'h0808, 16'hE000, 20'h02000, 20'h08080, 20'h00000, 20'h00000};
    vecs[3] = '{1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0, 7'h00, 16'h0000, 16'h8000, 20'h00000, 20'h00000, 20'h00000, 20'h00000};
    vecs[4] = '{1'b0, 20'h00000, 20'h00000, 1'b1, 1'b1, 7'h26, 16'hBEEF, 16'hC000, 20'hA6000, 20'h00000, 20'h00000, 20'h00000};
    vecs[5] = '{1'b1, 20'h12345, 20'hABCDE, 1'b1, 1'b0, 7'h7F, 16'hFFFF, 16'hF800, 20'h7F000, 20'hFFFF0, 20'h12345, 20'hABCDE};
    vecs[6] = '{1'b1, 20'h00001, 20'hFFFFF, 1'b1, 1'b1, 7'h00, 16'h1234, 16'hD800, 20'h80000, 20'h00000, 20'h00001, 20'hFFFFF};

    I_RESET     = 1'b1;
    I_PCM_LEFT  = '0;
    I_PCM_RIGHT = '0;
    I_PCM_VALID = 1'b0;
    I_CMD_VALID = 1'b0;
    I_CMD_RD    = 1'b0;
    I_CMD_ADDR  = '0;
    I_CMD_DATA  = '0;

    repeat (4) step();
    check("reset_outputs", {76'd0, O_SYNC, O_SDATA_OUT, O_STROBE, O_CMD_READY}, 80'd0);

    // first frame loads at the first edge after release
    I_RESET = 1'b0;
    step();
    check("release_first_strobe", {79'd0, O_STROBE}, 80'd1);
    check("release_ready", {79'd0, O_CMD_READY}, 80'd1);

    foreach (vecs[i]) begin
      wait_strobe($sformatf("v%0d_sync", i), prev_ready);
      n = nstart;
      I_PCM_VALID = vecs[i].pv;
      I_PCM_LEFT  = vecs[i].l;
      I_PCM_RIGHT = vecs[i].r;
      if (vecs[i].cmd) begin
        I_CMD_VALID = 1'b1;
        I_CMD_RD    = vecs[i].rd;
        I_CMD_ADDR  = vecs[i].a;
        I_CMD_DATA  = vecs[i].d;
        step();
        I_CMD_VALID = 1'b0;
        check($sformatf("v%0d_ready_after_accept", i), {79'd0, O_CMD_READY}, 80'd0);
        wait_strobe($sformatf("v%0d_load", i), prev_ready);
        check($sformatf("v%0d_ready_before_load", i), {79'd0, prev_ready}, 80'd0);
        check($sformatf("v%0d_ready_after_load", i), {79'd0, O_CMD_READY}, 80'd1);
      end
      check_frame($sformatf("v%0d", i), n, vecs[i].tag, vecs[i].s1, vecs[i].s2,
                  vecs[i].s3, vecs[i].s4);
    end

    // Command offered exactly at the load edge, then a second request while busy.
    I_PCM_VALID = 1'b0;
    wait_strobe("sim_sync", prev_ready);
    n = nstart;
    repeat (255) step();
    check("sim_pre_load_strobe", {79'd0, O_STROBE}, 80'd0);
    I_CMD_VALID = 1'b1;
    I_CMD_RD    = 1'b0;
    I_CMD_ADDR  = 7'h11;
    I_CMD_DATA  = 16'h5555;
    step();
    check("sim_load_strobe", {79'd0, O_STROBE}, 80'd1);
    check("sim_accepted_ready", {79'd0, O_CMD_READY}, 80'd0);
    I_CMD_ADDR  = 7'h22;
    I_CMD_DATA  = 16'hAAAA;
    step();
    check("sim_busy_ready", {79'd0, O_CMD_READY}, 80'd0);
    I_CMD_VALID = 1'b0;
    check_frame("sim_cur", n, 16'h8000, 20'h0, 20'h0, 20'h0, 20'h0);
    check_frame("sim_next", n + 1, 16'hE000, 20'h11000, 20'h55550, 20'h0, 20'h0);
    check_frame("sim_after", n + 2, 16'h8000, 20'h0, 20'h0, 20'h0, 20'h0);

    // Reset at counter 100 with a command pending.
    wait_strobe("rst_sync", prev_ready);
    I_CMD_VALID = 1'b1;
    I_CMD_RD    = 1'b0;
    I_CMD_ADDR  = 7'h33;
    I_CMD_DATA  = 16'h1234;
    step();
    I_CMD_VALID = 1'b0;
    check("rst_cmd_pending", {79'd0, O_CMD_READY}, 80'd0);
    repeat (98) step();
    I_RESET = 1'b1;
    step();
    check("rst_outputs", {76'd0, O_SYNC, O_SDATA_OUT, O_STROBE, O_CMD_READY}, 80'd0);
    repeat (2) step();
    I_RESET = 1'b0;
    n = nstart;
    step();
    check("rst_first_strobe", {79'd0, O_STROBE}, 80'd1);
    check("rst_ready", {79'd0, O_CMD_READY}, 80'd1);
    check_frame("rst_frame", n, 16'h8000, 20'h0, 20'h0, 20'h0, 20'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
